main_memory_arbiter: RTL

Two-port arbiter and access sequencer in front of the main memory array (1024 x 32-bit). It shares the single memory port between two cache controllers (port 0: instruction side, port 1: data side) using round-robin arbitration. It also models fixed main-memory access latency with a countdown. Each transaction is one 32-bit word read or write and completes with a one-cycle acknowledge to the granted requester.

---
 rtl/main_memory_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/main_memory_arbiter.sv
// Purpose: round-robin arbiter/sequencer sharing one main-memory port between two requesters.
// Latency: ack pulses MEM_LATENCY+1 cycles after a request is granted from IDLE.
// Backpressure: one access in flight; the losing requester waits with req held high.
module main_memory_arbiter #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // The countdown register is 4 bits wide, so the latency must fit in 1..15.
    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("main_memory_arbiter: MEM_LATENCY must be within 1..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic                  lg, lg_nxt;
    logic                  cmd_port, cmd_port_nxt;
    logic                  cmd_we, cmd_we_nxt;
    logic [ADDR_WIDTH-1:0] cmd_addr, cmd_addr_nxt;
    logic [DATA_WIDTH-1:0] cmd_wdata, cmd_wdata_nxt;
    logic                  ack0_nxt, ack1_nxt, busy_nxt;
    logic [DATA_WIDTH-1:0] rdata_nxt;
    logic                  win;

    // State, latched command and registered outputs; reset drops any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lg        <= 1'b1;
            cmd_port  <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            busy      <= 1'b0;
            rdata     <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lg        <= lg_nxt;
            cmd_port  <= cmd_port_nxt;
            cmd_we    <= cmd_we_nxt;
            cmd_addr  <= cmd_addr_nxt;
            cmd_wdata <= cmd_wdata_nxt;
            ack0      <= ack0_nxt;
            ack1      <= ack1_nxt;
            busy      <= busy_nxt;
            rdata     <= rdata_nxt;
        end
    end

    // Arbitration, latency countdown and response sequencing.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        lg_nxt        = lg;
        cmd_port_nxt  = cmd_port;
        cmd_we_nxt    = cmd_we;
        cmd_addr_nxt  = cmd_addr;
        cmd_wdata_nxt = cmd_wdata;
        ack0_nxt      = 1'b0;
        ack1_nxt      = 1'b0;
        busy_nxt      = busy;
        rdata_nxt     = rdata;
        // On a tie the port that was not granted last wins.
        win           = (req0 && req1) ? ~lg : req1;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    lg_nxt        = win;
                    cmd_port_nxt  = win;
                    cmd_we_nxt    = win ? we1 : we0;
                    cmd_addr_nxt  = win ? addr1 : addr0;
                    cmd_wdata_nxt = win ? wdata1 : wdata0;
                    cnt_nxt       = 4'(MEM_LATENCY - 1);
                    busy_nxt      = 1'b1;
                    state_nxt     = BUSY;
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    if (!cmd_we) begin
                        rdata_nxt = mem_rdata;
                    end
                    ack0_nxt  = ~cmd_port;
                    ack1_nxt  = cmd_port;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Memory port is a decode of the state and the latched command.
    always_comb begin
        mem_en    = (state == BUSY);
        mem_we    = (state == BUSY) && (cnt == 4'd0) && cmd_we;
        mem_addr  = cmd_addr;
        mem_wdata = cmd_wdata;
    end

endmodule
